// File: rtl/ysq_pkg.sv
// Shared types and constants for the nibble-serial fetch path.
// The nibble-enable encodings are also used by the instruction register.
package ysq_pkg;

  localparam int PC_W_DEF = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] EN_NIB0 = 4'b1000;
  localparam logic [3:0] EN_NIB1 = 4'b0100;
  localparam logic [3:0] EN_NIB2 = 4'b0010;
  localparam logic [3:0] EN_NIB3 = 4'b0001;

  function automatic logic [3:0] nib_en(input logic [1:0] idx);
    case (idx)
      2'd0:    nib_en = EN_NIB0;
      2'd1:    nib_en = EN_NIB1;
      2'd2:    nib_en = EN_NIB2;
      default: nib_en = EN_NIB3;
    endcase
  endfunction

endpackage

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: four nibble reads per 16-bit instruction,
// MS nibble first, with PC ownership, jump loads and abort.
module fetch_seq
  import ysq_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_in,
  output logic            mem_req,
  output logic [PC_W+1:0] mem_addr,
  input  logic            mem_ack,
  output logic [3:0]      ir_en,
  output logic            busy,
  output logic            fetch_done,
  output logic [PC_W-1:0] pc
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_nib;
  logic [PC_W-1:0] r_pc;
  logic            w_ack_ok;

  // abort beats mem_ack: an aborted cycle never steers a nibble
  always_comb begin
    w_next   = r_state;
    w_ack_ok = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = REQ;
      REQ: begin
        if (abort) begin
          w_next = IDLE;
        end else if (mem_ack) begin
          w_ack_ok = 1'b1;
          if (r_nib == 2'd3) w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_nib   <= 2'd0;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        r_nib <= 2'd0;
        if (pc_load) r_pc <= pc_in;
      end else if (r_state == REQ && abort) begin
        r_nib <= 2'd0;
      end else if (w_ack_ok) begin
        r_nib <= r_nib + 2'd1;
        if (r_nib == 2'd3) r_pc <= r_pc + PC_ONE;
      end
    end
  end

  assign mem_req    = (r_state == REQ);
  assign busy       = (r_state == REQ);
  assign fetch_done = (r_state == DONE);
  assign mem_addr   = {r_pc, r_nib};
  assign ir_en      = w_ack_ok ? nib_en(r_nib) : 4'b0000;
  assign pc         = r_pc;

endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboarded bench for fetch_seq: a transaction-level fetch model queues
// expected nibble/done events; a negedge monitor pops and compares them.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        pc_load = 1'b0;
  logic [12:0] pc_in = '0;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [3:0]  ir_en;
  logic        busy;
  logic        fetch_done;
  logic [12:0] pc;

  fetch_seq #(.PC_W(13), .RESET_PC(13'h0000)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pc_load(pc_load), .pc_in(pc_in), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .ir_en(ir_en),
    .busy(busy), .fetch_done(fetch_done), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        done;
    logic [14:0] addr;
    logic [3:0]  en;
    logic [12:0] pc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [12:0] m_pc = 13'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h @%0t", name, act, exp, $time);
    end
  endtask

  // monitor: every nibble strobe or done pulse must match the next queued event
  initial forever begin
    @(negedge clk);
    if (!reset && (ir_en !== 4'b0000 || fetch_done !== 1'b0)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event ir_en=%b fetch_done=%b @%0t", ir_en, fetch_done, $time);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.done) begin
          chk("done_flag", {31'd0, fetch_done}, 32'd1);
          chk("done_pc", {19'd0, pc}, {19'd0, mon_e.pc});
          chk("done_iren", {28'd0, ir_en}, 32'd0);
        end else begin
          chk("nib_en", {28'd0, ir_en}, {28'd0, mon_e.en});
          chk("nib_addr", {17'd0, mem_addr}, {17'd0, mon_e.addr});
          chk("nib_req", {31'd0, mem_req}, 32'd1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  task automatic drive_idle(input bit ld, input logic [12:0] v);
    @(posedge clk); #1;
    start   = 1'b0;
    pc_load = ld;
    pc_in   = v;
    abort   = 1'($urandom_range(0, 1));
    mem_ack = 1'($urandom_range(0, 1));
    if (ld) m_pc = v;
  endtask

  // One fetch: w[n] wait cycles before nibble n's ack; ab = nibble to abort on (-1 none)
  task automatic fetch(input bit ld, input logic [12:0] v, input logic [3:0][3:0] w, input int ab);
    @(posedge clk); #1;
    start   = 1'b1;
    pc_load = ld;
    pc_in   = v;
    abort   = 1'($urandom_range(0, 1));
    mem_ack = 1'($urandom_range(0, 1));
    if (ld) m_pc = v;
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < int'(w[n]); k++) begin
        @(posedge clk); #1;
        start   = 1'($urandom_range(0, 1));
        pc_load = 1'($urandom_range(0, 1));
        pc_in   = 13'($urandom);
        abort   = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("wait_req", {31'd0, mem_req}, 32'd1);
        chk("wait_addr", {17'd0, mem_addr}, {17'd0, m_pc, 2'(n)});
        chk("wait_iren", {28'd0, ir_en}, 32'd0);
      end
      @(posedge clk); #1;
      start   = 1'($urandom_range(0, 1));
      pc_load = 1'($urandom_range(0, 1));
      pc_in   = 13'($urandom);
      mem_ack = 1'b1;
      abort   = (ab == n);
      if (ab == n) begin
        @(negedge clk);
        chk("abort_iren", {28'd0, ir_en}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; pc_load = 1'b0; abort = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        chk("abort_req", {31'd0, mem_req}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_pc", {19'd0, pc}, {19'd0, m_pc});
        chk("abort_addr", {17'd0, mem_addr}, {17'd0, m_pc, 2'b00});
        return;
      end
      q.push_back('{done: 1'b0, addr: {m_pc, 2'(n)}, en: 4'b1000 >> n, pc: 13'h0});
    end
    m_pc = m_pc + 13'd1;
    q.push_back('{done: 1'b1, addr: 15'h0, en: 4'h0, pc: m_pc});
    // done cycle: start/abort/ack must all be ignored
    @(posedge clk); #1;
    start   = 1'b1;
    pc_load = 1'($urandom_range(0, 1));
    pc_in   = 13'($urandom);
    abort   = 1'($urandom_range(0, 1));
    mem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("done_cycle", {31'd0, fetch_done}, 32'd1);
    chk("done_req", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    logic [3:0][3:0] w;
    int ab;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, fetch_done}, 32'd0);
    chk("rst_iren", {28'd0, ir_en}, 32'd0);
    chk("rst_pc", {19'd0, pc}, 32'd0);
    chk("rst_addr", {17'd0, mem_addr}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    fetch(1'b0, 13'h0, '0, -1);                       // zero-wait from reset
    fetch(1'b1, 13'h0ABC, '0, -1);                    // load + start same cycle
    w = '0; w[1] = 4'd3;
    fetch(1'b0, 13'h0, w, -1);                        // 3 waits on nib 1
    drive_idle(1'b1, 13'h1FFF);
    fetch(1'b0, 13'h0, '0, -1);                       // wrap to 0
    chk("wrap_pc", {19'd0, pc}, 32'd0);
    fetch(1'b0, 13'h0, '0, 2);                        // abort on nib 2
    fetch(1'b0, 13'h0, '0, -1);                       // refetch from nib 0

    // reset during nib 1
    @(posedge clk); #1;
    start = 1'b1; pc_load = 1'b1; pc_in = 13'h0123; mem_ack = 1'b0; abort = 1'b0;
    m_pc = 13'h0123;
    @(posedge clk); #1;
    start = 1'b0; pc_load = 1'b0; mem_ack = 1'b1;
    q.push_back('{done: 1'b0, addr: {m_pc, 2'd0}, en: 4'b1000, pc: 13'h0});
    @(posedge clk); #1;
    reset = 1'b1; mem_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_pc = 13'h0000;
    @(negedge clk);
    chk("mrst_req", {31'd0, mem_req}, 32'd0);
    chk("mrst_iren", {28'd0, ir_en}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_pc", {19'd0, pc}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      for (int n = 0; n < 4; n++)
        w[n] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      if ($urandom_range(0, 3) == 0) drive_idle(1'b0, 13'h0);
      fetch($urandom_range(0, 2) == 0, 13'($urandom), w, ab);
    end

    drive_idle(1'b0, 13'h0);
    drive_idle(1'b0, 13'h0);
    @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
